current_clarke: RTL

CURRENT_CLARKE -- requirements
Module: current_clarke

---
 rtl/foc_pkg.sv | 24 ++
 rtl/current_clarke_if.sv | 28 ++
 rtl/clarke_beta_mul.sv | 48 ++++
 rtl/current_clarke.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
// Shared definitions for the field-oriented-control current path.
// Holds the Clarke FSM state encoding, the Q15 constant 1/sqrt(3),
// the ADC midscale used as the power-up offset, and the data widths.
package foc_pkg;

   localparam int ADC_W              = 12;
   localparam int CUR_W              = 16;
   localparam int ADC_MIDSCALE       = 2048;
   localparam int ONE_OVER_SQRT3_Q15 = 18919;

   // CAL   : averaging offset-calibration samples
   // IDLE  : waiting for a sample pair
   // SUB   : offset subtraction and iu + 2*iv
   // MUL   : constant multiply by 1/sqrt(3)
   // OUT   : rounding and output register load
   typedef enum logic [2:0] {
      ST_CAL,
      ST_IDLE,
      ST_SUB,
      ST_MUL,
      ST_OUT
   } state_t;

endpackage

// File: rtl/current_clarke_if.sv
// Bundles the sample/calibration handshake and the alpha/beta result
// of the current Clarke transform.
//   master : drives ADC codes, acquire/calibration pulses; observes results
//   slave  : the transform side, consuming samples and producing results
interface current_clarke_if;
   import foc_pkg::*;

   logic [ADC_W-1:0]        iu;
   logic [ADC_W-1:0]        iv;
   logic                    acquire_done;
   logic                    cal_start;
   logic signed [CUR_W-1:0] ialpha;
   logic signed [CUR_W-1:0] ibeta;
   logic                    valid;
   logic                    cal_done;
   logic                    overrun;

   modport master (
      output iu, iv, acquire_done, cal_start,
      input  ialpha, ibeta, valid, cal_done, overrun
   );

   modport slave (
      input  iu, iv, acquire_done, cal_start,
      output ialpha, ibeta, valid, cal_done, overrun
   );

endinterface

// File: rtl/clarke_beta_mul.sv
// Multiplies the 15-bit signed sum (iu + 2*iv) by 1/sqrt(3) in Q15 and
// rounds the product back to an integer current (round half up).
//   clk, rst : clock, asynchronous active-high reset
//   en       : load the product register this cycle
//   sum_i    : signed iu + 2*iv
//   beta_o   : signed, rounded (prod + 2^14) >>> 15 of the held product
module clarke_beta_mul
   import foc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic signed [14:0]      sum_i,
   output logic signed [CUR_W-1:0] beta_o
);

   localparam logic signed [29:0] COEF = 30'(ONE_OVER_SQRT3_Q15);
   localparam logic signed [29:0] HALF = 30'sd16384;

   logic signed [29:0] prod_q;
   logic signed [29:0] prod_d;
   logic signed [29:0] sum_ext;
   logic signed [29:0] rnd;

   // |sum| <= 12285, so the product stays well inside 30 signed bits.
   always_comb begin
      sum_ext = {{15{sum_i[14]}}, sum_i};
      prod_d  = prod_q;
      if (en) begin
         prod_d = sum_ext * COEF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q <= '0;
      end else begin
         prod_q <= prod_d;
      end
   end

   // Arithmetic shift by 15 is taking bits [29:15]; the result fits 15 bits.
   always_comb begin
      rnd    = prod_q + HALF;
      beta_o = {rnd[29], rnd[29:15]};
   end

endmodule

// File: rtl/current_clarke.sv
// Offset-calibrated Clarke transform for two measured phase currents.
// Calibration averages 2^CAL_SHIFT sample pairs to find the ADC offsets,
// then each sample pair passes SUB -> MUL -> OUT and yields
//   alpha = iu, beta = (iu + 2*iv) / sqrt(3)  three cycles after capture.
//   iClk, iRst     : clock, asynchronous active-high reset
//   iIu, iIv       : unsigned ADC codes, valid with iAcquire_done
//   iAcquire_done  : one-cycle sample strobe
//   iCal_start     : one-cycle recalibration request
//   oIalpha/oIbeta : signed results, held between oValid pulses
//   oValid         : one-cycle result strobe
//   oCal_done      : offsets are valid
//   oOverrun       : one-cycle pulse when a sample was dropped
module current_clarke
   import foc_pkg::*;
#(
   parameter int CAL_SHIFT = 4
)
(
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic [ADC_W-1:0]        iIu,
   input  logic [ADC_W-1:0]        iIv,
   input  logic                    iAcquire_done,
   input  logic                    iCal_start,
   output logic signed [CUR_W-1:0] oIalpha,
   output logic signed [CUR_W-1:0] oIbeta,
   output logic                    oValid,
   output logic                    oCal_done,
   output logic                    oOverrun
);

   localparam int               ACC_W    = ADC_W + CAL_SHIFT;
   localparam int               CNT_W    = CAL_SHIFT;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   state_t                  state_q, state_d;
   logic [ACC_W-1:0]        acc_u_q, acc_u_d, acc_v_q, acc_v_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADC_W-1:0]        off_u_q, off_u_d, off_v_q, off_v_d;
   logic [ADC_W-1:0]        samp_u_q, samp_u_d, samp_v_q, samp_v_d;
   logic signed [12:0]      iu_q, iu_d, iv_q, iv_d;
   logic signed [14:0]      sum_q, sum_d;
   logic signed [CUR_W-1:0] ialpha_q, ialpha_d, ibeta_q, ibeta_d;
   logic                    valid_q, valid_d;
   logic                    cal_done_q, cal_done_d;
   logic                    drop_q, drop_d;
   logic                    overrun_q, overrun_d;

   logic [ACC_W-1:0]        acc_u_sum, acc_v_sum;
   logic signed [12:0]      iu_w, iv_w;
   logic signed [14:0]      sum_w;
   logic signed [CUR_W-1:0] beta_w;
   logic                    mul_en;

   clarke_beta_mul u_beta_mul (
      .clk    (iClk),
      .rst    (iRst),
      .en     (mul_en),
      .sum_i  (sum_q),
      .beta_o (beta_w)
   );

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_CAL;
      end else begin
         state_q <= state_d;
      end
   end

   // OUT also accepts a new sample, so back-to-back samples spaced three
   // cycles apart stream without a bubble. A recalibration request wins
   // over a simultaneous sample in IDLE and CAL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CAL: begin
            if (!iCal_start && iAcquire_done && (cnt_q == CNT_LAST)) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (iCal_start) begin
               state_d = ST_CAL;
            end else if (iAcquire_done) begin
               state_d = ST_SUB;
            end
         end
         ST_SUB:  state_d = ST_MUL;
         ST_MUL:  state_d = ST_OUT;
         ST_OUT:  state_d = iAcquire_done ? ST_SUB : ST_IDLE;
         default: state_d = ST_CAL;
      endcase
   end

   always_comb begin
      acc_u_sum = acc_u_q + {{CAL_SHIFT{1'b0}}, iIu};
      acc_v_sum = acc_v_q + {{CAL_SHIFT{1'b0}}, iIv};
      iu_w      = $signed({1'b0, samp_u_q}) - $signed({1'b0, off_u_q});
      iv_w      = $signed({1'b0, samp_v_q}) - $signed({1'b0, off_v_q});
      sum_w     = $signed({{2{iu_w[12]}}, iu_w}) + $signed({iv_w[12], iv_w, 1'b0});
   end

   // Datapath next values. A sample dropped in SUB/MUL is flagged first and
   // reported one cycle later so oOverrun lines up with the pipeline slot.
   always_comb begin
      acc_u_d    = acc_u_q;
      acc_v_d    = acc_v_q;
      cnt_d      = cnt_q;
      off_u_d    = off_u_q;
      off_v_d    = off_v_q;
      samp_u_d   = samp_u_q;
      samp_v_d   = samp_v_q;
      iu_d       = iu_q;
      iv_d       = iv_q;
      sum_d      = sum_q;
      ialpha_d   = ialpha_q;
      ibeta_d    = ibeta_q;
      valid_d    = 1'b0;
      cal_done_d = cal_done_q;
      drop_d     = 1'b0;
      overrun_d  = drop_q;
      mul_en     = 1'b0;
      case (state_q)
         ST_CAL: begin
            if (iCal_start) begin
               acc_u_d = '0;
               acc_v_d = '0;
               cnt_d   = '0;
            end else if (iAcquire_done) begin
               if (cnt_q == CNT_LAST) begin
                  off_u_d    = acc_u_sum[ACC_W-1:CAL_SHIFT];
                  off_v_d    = acc_v_sum[ACC_W-1:CAL_SHIFT];
                  cal_done_d = 1'b1;
                  acc_u_d    = '0;
                  acc_v_d    = '0;
                  cnt_d      = '0;
               end else begin
                  acc_u_d = acc_u_sum;
                  acc_v_d = acc_v_sum;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_IDLE: begin
            if (iCal_start) begin
               acc_u_d    = '0;
               acc_v_d    = '0;
               cnt_d      = '0;
               cal_done_d = 1'b0;
            end else if (iAcquire_done) begin
               samp_u_d = iIu;
               samp_v_d = iIv;
            end
         end
         ST_SUB: begin
            iu_d   = iu_w;
            iv_d   = iv_w;
            sum_d  = sum_w;
            drop_d = iAcquire_done;
         end
         ST_MUL: begin
            mul_en = 1'b1;
            drop_d = iAcquire_done;
         end
         ST_OUT: begin
            ialpha_d = {{(CUR_W-13){iu_q[12]}}, iu_q};
            ibeta_d  = beta_w;
            valid_d  = 1'b1;
            if (iAcquire_done) begin
               samp_u_d = iIu;
               samp_v_d = iIv;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         acc_u_q    <= '0;
         acc_v_q    <= '0;
         cnt_q      <= '0;
         off_u_q    <= ADC_W'(ADC_MIDSCALE);
         off_v_q    <= ADC_W'(ADC_MIDSCALE);
         samp_u_q   <= '0;
         samp_v_q   <= '0;
         iu_q       <= '0;
         iv_q       <= '0;
         sum_q      <= '0;
         ialpha_q   <= '0;
         ibeta_q    <= '0;
         valid_q    <= 1'b0;
         cal_done_q <= 1'b0;
         drop_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         acc_u_q    <= acc_u_d;
         acc_v_q    <= acc_v_d;
         cnt_q      <= cnt_d;
         off_u_q    <= off_u_d;
         off_v_q    <= off_v_d;
         samp_u_q   <= samp_u_d;
         samp_v_q   <= samp_v_d;
         iu_q       <= iu_d;
         iv_q       <= iv_d;
         sum_q      <= sum_d;
         ialpha_q   <= ialpha_d;
         ibeta_q    <= ibeta_d;
         valid_q    <= valid_d;
         cal_done_q <= cal_done_d;
         drop_q     <= drop_d;
         overrun_q  <= overrun_d;
      end
   end

   assign oIalpha   = ialpha_q;
   assign oIbeta    = ibeta_q;
   assign oValid    = valid_q;
   assign oCal_done = cal_done_q;
   assign oOverrun  = overrun_q;

endmodule
